// File: rtl/out_flow_demux_pkg.sv
// Shared types and field helpers for the tagged-pel output demultiplexer.
// Widths of the tagged input word and of the configuration word live here.
package out_flow_demux_pkg;

  localparam int TAG_W  = 2;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 13;
  localparam int IN_W   = TAG_W + DATA_W;
  localparam int CFG_W  = TAG_W + CNT_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } flow_state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [IN_W-1:0] din);
    return din[IN_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] get_pel(input logic [IN_W-1:0] din);
    return din[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/flow_fifo.sv
// Single-flow first-word-fall-through FIFO; head is visible on dout whenever
// empty is low. full is evaluated from the registered count before any pop.
module flow_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/out_flow_demux.sv
// Routes the tagged pel stream into per-flow FIFOs and tracks per-flow block
// completion against a programmed element count.
module out_flow_demux
  import out_flow_demux_pkg::*;
#(
  parameter int FLUX  = 4,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_W-1:0]              in_din,
  input  logic                         in_write,
  output logic [FLUX-1:0]              in_full,
  input  logic [CFG_W-1:0]             cfg_din,
  input  logic                         cfg_write,
  input  logic [FLUX-1:0]              rd_en,
  output logic [FLUX-1:0][DATA_W-1:0]  dout,
  output logic [FLUX-1:0]              empty,
  output logic [FLUX-1:0]              done,
  output logic [FLUX-1:0]              err_overflow,
  output logic [FLUX-1:0]              err_unexpected,
  output logic [FLUX-1:0][1:0]         dbg_state,
  output logic [FLUX-1:0][CNT_W-1:0]   dbg_remaining
);

  // Handshake: a pel is accepted for flow t when in_write is high, its tag is
  // t and in_full[t] (registered) is low; otherwise it is dropped.
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_pel;
  logic [TAG_W-1:0]  cfg_tag;
  logic [CNT_W-1:0]  cfg_cnt;

  assign in_tag  = get_tag(in_din);
  assign in_pel  = get_pel(in_din);
  assign cfg_tag = cfg_din[CFG_W-1:CNT_W];
  assign cfg_cnt = cfg_din[CNT_W-1:0];

  for (genvar f = 0; f < FLUX; f++) begin : g_flow
    logic             push;
    logic             accepted;
    logic             load;
    flow_state_t      state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             ovf_q, unexp_q, unexp_d;

    assign push     = in_write && (in_tag == TAG_W'(f));
    assign accepted = push && !in_full[f];
    assign load     = cfg_write && (cfg_tag == TAG_W'(f)) && (cfg_cnt != '0);

    flow_fifo #(.DEPTH(DEPTH), .DW(DATA_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (in_pel),
      .pop   (rd_en[f]),
      .dout  (dout[f]),
      .full  (in_full[f]),
      .empty (empty[f])
    );

    // A reload in the same cycle as an accepted pel counts that pel against
    // the new block, so N=1 completes immediately.
    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      unexp_d = 1'b0;
      if (load) begin
        state_d = ACTIVE;
        rem_d   = accepted ? cfg_cnt - CNT_W'(1) : cfg_cnt;
        if (accepted && cfg_cnt == CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else if (accepted) begin
        if (state_q == ACTIVE) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          unexp_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        rem_q   <= '0;
        done_q  <= 1'b0;
        ovf_q   <= 1'b0;
        unexp_q <= 1'b0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
        done_q  <= done_d;
        ovf_q   <= ovf_q | (push && in_full[f]);
        unexp_q <= unexp_q | unexp_d;
      end
    end

    assign done[f]           = done_q;
    assign err_overflow[f]   = ovf_q;
    assign err_unexpected[f] = unexp_q;
    assign dbg_state[f]      = state_q;
    assign dbg_remaining[f]  = rem_q;
  end

endmodule

// File: tb/tb_out_flow_demux.sv
// Directed bench for out_flow_demux: a queue-based flow model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_out_flow_demux;
  import out_flow_demux_pkg::*;

  localparam int FLUX  = 4;
  localparam int DEPTH = 16;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic [IN_W-1:0]             in_din = '0;
  logic                        in_write = 1'b0;
  logic [FLUX-1:0]             in_full;
  logic [CFG_W-1:0]            cfg_din = '0;
  logic                        cfg_write = 1'b0;
  logic [FLUX-1:0]             rd_en = '0;
  logic [FLUX-1:0][DATA_W-1:0] dout;
  logic [FLUX-1:0]             empty;
  logic [FLUX-1:0]             done;
  logic [FLUX-1:0]             err_overflow;
  logic [FLUX-1:0]             err_unexpected;
  logic [FLUX-1:0][1:0]        dbg_state;
  logic [FLUX-1:0][CNT_W-1:0]  dbg_remaining;

  int n_checks = 0;
  int n_errors = 0;

  out_flow_demux #(.FLUX(FLUX), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_din         (in_din),
    .in_write       (in_write),
    .in_full        (in_full),
    .cfg_din        (cfg_din),
    .cfg_write      (cfg_write),
    .rd_en          (rd_en),
    .dout           (dout),
    .empty          (empty),
    .done           (done),
    .err_overflow   (err_overflow),
    .err_unexpected (err_unexpected),
    .dbg_state      (dbg_state),
    .dbg_remaining  (dbg_remaining)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int f, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, f, act, exp, $time);
    end
  endtask

  // flow model: data queues, block state, remaining counts, sticky errors
  logic [DATA_W-1:0] exp_q [FLUX][$];
  flow_state_t       m_state [FLUX];
  int                m_rem   [FLUX];
  bit                m_done  [FLUX];
  bit                m_ovf   [FLUX];
  bit                m_unexp [FLUX];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < FLUX; f++) begin
        exp_q[f].delete();
        m_state[f] = IDLE;
        m_rem[f]   = 0;
        m_done[f]  = 0;
        m_ovf[f]   = 0;
        m_unexp[f] = 0;
      end
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        bit push, acc, load;
        int n;
        push = in_write && (int'(in_din[9:8]) == f);
        acc  = push && (exp_q[f].size() < DEPTH);
        if (push && !acc) m_ovf[f] = 1;
        if (rd_en[f] && exp_q[f].size() > 0) void'(exp_q[f].pop_front());
        if (acc) exp_q[f].push_back(in_din[7:0]);
        m_done[f] = 0;
        n    = int'(cfg_din[12:0]);
        load = cfg_write && (int'(cfg_din[14:13]) == f) && (n > 0);
        if (load) begin
          m_state[f] = ACTIVE;
          m_rem[f]   = acc ? n - 1 : n;
        end else if (acc) begin
          if (m_state[f] == ACTIVE) m_rem[f] = m_rem[f] - 1;
          else m_unexp[f] = 1;
        end
        if ((load || acc) && m_state[f] == ACTIVE && m_rem[f] == 0) begin
          m_state[f] = DONE;
          m_done[f]  = 1;
        end
      end
    end
  end

  // per-cycle compare against the model
  always @(posedge clk) begin
    #2;
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        check("empty", f, 32'(empty[f]), 32'(exp_q[f].size() == 0));
        check("in_full", f, 32'(in_full[f]), 32'(exp_q[f].size() == DEPTH));
        if (exp_q[f].size() > 0) check("dout", f, 32'(dout[f]), 32'(exp_q[f][0]));
        check("done", f, 32'(done[f]), 32'(m_done[f]));
        check("err_overflow", f, 32'(err_overflow[f]), 32'(m_ovf[f]));
        check("err_unexpected", f, 32'(err_unexpected[f]), 32'(m_unexp[f]));
        check("state", f, 32'(dbg_state[f]), 32'(m_state[f]));
        check("remaining", f, 32'(dbg_remaining[f]), 32'(m_rem[f]));
      end
    end
  end

  // driver tasks: inputs change on the falling edge, return 3 units after the
  // following rising edge so literal checks see post-edge outputs
  task automatic drive(input logic w, input logic [1:0] t, input logic [7:0] p,
                       input logic cw, input logic [1:0] ct, input logic [12:0] n,
                       input logic [3:0] rd);
    @(negedge clk);
    in_write  = w;
    in_din    = {t, p};
    cfg_write = cw;
    cfg_din   = {ct, n};
    rd_en     = rd;
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input logic [3:0] rd);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 13'd0, rd);
  endtask

  task automatic cfg(input logic [1:0] t, input logic [12:0] n);
    drive(1'b0, 2'd0, 8'h00, 1'b1, t, n, 4'b0000);
  endtask

  task automatic wr(input logic [1:0] t, input logic [7:0] p, input logic [3:0] rd);
    drive(1'b1, t, p, 1'b0, 2'd0, 13'd0, rd);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #3;
    check("rst_empty", 0, 32'(empty), 32'hF);
    check("rst_in_full", 0, 32'(in_full), 32'h0);
    check("rst_done", 0, 32'(done), 32'h0);
    check("rst_errs", 0, 32'({err_overflow, err_unexpected}), 32'h0);
    check("rst_state", 0, 32'(dbg_state), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(4'b0000);

    // routing, 1-cycle FWFT latency
    cfg(2'd0, 13'd4);
    cfg(2'd1, 13'd4);
    wr(2'd0, 8'h10, 4'b0000);
    check("route_first_empty", 0, 32'(empty[0]), 32'h0);
    check("route_first_dout", 0, 32'(dout[0]), 32'h10);
    check("route_other_empty", 1, 32'(empty[1]), 32'h1);
    wr(2'd1, 8'h11, 4'b0000);
    wr(2'd0, 8'h12, 4'b0000);
    wr(2'd1, 8'h13, 4'b0000);
    check("route_dout1", 1, 32'(dout[1]), 32'h11);
    idle(4'b0011);
    check("route_dout0_2nd", 0, 32'(dout[0]), 32'h12);
    check("route_dout1_2nd", 1, 32'(dout[1]), 32'h13);
    check("route_rem0", 0, 32'(dbg_remaining[0]), 32'd2);
    idle(4'b0011);
    check("route_drained", 0, 32'(empty[1:0]), 32'h3);

    // backpressure and overflow drop
    cfg(2'd3, 13'd20);
    for (int i = 0; i < 17; i++) begin
      wr(2'd3, 8'h30 + 8'(i), 4'b0000);
      if (i == 14) check("bp_not_full", 3, 32'(in_full[3]), 32'h0);
      if (i == 15) check("bp_full", 3, 32'(in_full[3]), 32'h1);
    end
    check("bp_overflow", 3, 32'(err_overflow[3]), 32'h1);
    check("bp_remaining", 3, 32'(dbg_remaining[3]), 32'd4);
    check("bp_head", 3, 32'(dout[3]), 32'h30);
    repeat (16) idle(4'b1000);
    check("bp_drained", 3, 32'(empty[3]), 32'h1);

    // completion over a 64-pel block with continuous draining
    cfg(2'd2, 13'd64);
    for (int i = 0; i < 64; i++) begin
      wr(2'd2, 8'(i), 4'b0100);
      if (i == 62) check("cmp_no_early_done", 2, 32'(done[2]), 32'h0);
    end
    check("cmp_done", 2, 32'(done[2]), 32'h1);
    check("cmp_state", 2, 32'(dbg_state[2]), 32'(DONE));
    idle(4'b0100);
    check("cmp_done_single", 2, 32'(done[2]), 32'h0);
    check("cmp_no_unexp", 2, 32'(err_unexpected[2]), 32'h0);
    wr(2'd2, 8'hEE, 4'b0000);
    check("cmp_unexpected", 2, 32'(err_unexpected[2]), 32'h1);
    idle(4'b0100);

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) wr(2'd2, 8'h50 + 8'(i), 4'b0000);
    check("mid_filled", 2, 32'(empty[2]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_empty", 0, 32'(empty), 32'hF);
    check("mid_rst_in_full", 0, 32'(in_full), 32'h0);
    check("mid_rst_done", 0, 32'(done), 32'h0);
    check("mid_rst_unexp", 2, 32'(err_unexpected[2]), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #3;
    check("mid_state_idle", 2, 32'(dbg_state[2]), 32'(IDLE));
    check("mid_rem_zero", 2, 32'(dbg_remaining[2]), 32'd0);

    // reload together with an accepted pel, N=1
    drive(1'b1, 2'd1, 8'h55, 1'b1, 2'd1, 13'd1, 4'b0000);
    check("same_done", 1, 32'(done[1]), 32'h1);
    check("same_no_err", 1, 32'(err_unexpected[1]), 32'h0);
    check("same_dout", 1, 32'(dout[1]), 32'h55);
    idle(4'b0010);
    check("same_done_single", 1, 32'(done[1]), 32'h0);

    // push and pop on a full FIFO: push rejected, pop performed
    for (int i = 0; i < 16; i++) wr(2'd0, 8'hA0 + 8'(i), 4'b0000);
    check("pp_full", 0, 32'(in_full[0]), 32'h1);
    drive(1'b1, 2'd0, 8'hFF, 1'b0, 2'd0, 13'd0, 4'b0001);
    check("pp_overflow", 0, 32'(err_overflow[0]), 32'h1);
    check("pp_not_full", 0, 32'(in_full[0]), 32'h0);
    check("pp_head", 0, 32'(dout[0]), 32'hA1);
    repeat (14) idle(4'b0001);
    check("pp_last_present", 0, 32'(empty[0]), 32'h0);
    check("pp_last_value", 0, 32'(dout[0]), 32'hAF);
    idle(4'b0001);
    check("pp_15_entries", 0, 32'(empty[0]), 32'h1);
    idle(4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
